// File: rtl/jt900h_ram_arb.sv
// jt900h_ram_arb
// Two-requester arbiter in front of a single 16-bit RAM port.
// Requester 0 is the CPU, requester 1 is the debug/dump port. One access is
// in flight at a time: IDLE -> ACCESS -> DONE -> IDLE, every step qualified
// by cen. An access that sees no ram_rdy within TOUT cen cycles is aborted
// and reported through err together with ack.
//
// Ports
//   clk       in   1   clock, all state on the rising edge
//   rst_n     in   1   asynchronous active-low reset
//   cen       in   1   clock enable, qualifies every state change
//   req       in   2   access request (bit0 = CPU, bit1 = debug port)
//   addr      in  48   {addr1, addr0} 24-bit byte address per requester
//   we        in   2   per-requester write strobe (1 = write)
//   din       in  32   {din1, din0} 16-bit write data per requester
//   ack       out  2   per-requester completion pulse
//   err       out  2   per-requester timeout flag, valid with ack
//   dout      out 16   read data of the last completed access
//   grant     out  1   index of the current or last owner
//   ram_cs    out  1   RAM access active
//   ram_we    out  1   RAM write
//   ram_addr  out 24   RAM address
//   ram_din   out 16   RAM write data
//   ram_dout  in  16   RAM read data
//   ram_rdy   in   1   RAM access complete

module jt900h_ram_arb #(
    parameter int unsigned TOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [1:0]  req,
    input  logic [47:0] addr,
    input  logic [1:0]  we,
    input  logic [31:0] din,
    output logic [1:0]  ack,
    output logic [1:0]  err,
    output logic [15:0] dout,
    output logic        grant,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [23:0] ram_addr,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    input  logic        ram_rdy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] TOUT_W = 4'(TOUT);

    state_t      state_q;
    logic [3:0]  timer_q;
    logic        last_q;
    logic        grant_q;
    logic [1:0]  ack_q;
    logic [1:0]  err_q;
    logic [15:0] dout_q;
    logic        ram_cs_q;
    logic        ram_we_q;
    logic [23:0] ram_addr_q;
    logic [15:0] ram_din_q;

    logic        win_d;
    logic [3:0]  timer_d;
    logic        timeout_d;
    logic [1:0]  owner_onehot_d;

    // A lone requester wins outright; on a tie the one not served last wins.
    always_comb begin
        win_d          = req[1] & (~req[0] | ~last_q);
        timer_d        = timer_q + 4'd1;
        timeout_d      = (timer_d == TOUT_W);
        owner_onehot_d = grant_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            last_q     <= 1'b1;
            grant_q    <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
            dout_q     <= '0;
            ram_cs_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else if (cen) begin
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        grant_q    <= win_d;
                        ram_addr_q <= win_d ? addr[47:24] : addr[23:0];
                        ram_din_q  <= win_d ? din[31:16]  : din[15:0];
                        ram_we_q   <= we[win_d];
                        ram_cs_q   <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // ram_rdy is checked first so a response arriving on the
                    // very edge the timer expires still completes cleanly.
                    if (ram_rdy) begin
                        if (!ram_we_q) dout_q <= ram_dout;
                        ram_cs_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        ack_q    <= owner_onehot_d;
                        state_q  <= DONE;
                    end else if (timeout_d) begin
                        timer_q  <= timer_d;
                        dout_q   <= 16'hFFFF;
                        ram_cs_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        ack_q    <= owner_onehot_d;
                        err_q    <= owner_onehot_d;
                        state_q  <= DONE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    err_q   <= '0;
                    last_q  <= grant_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    ack_q    <= '0;
                    err_q    <= '0;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign dout     = dout_q;
    assign grant    = grant_q;
    assign ram_cs   = ram_cs_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule
